// File: rtl/rp_hdr_seq.sv
// rp_hdr_seq: sector-header sequencer for the RPxx header CRC block.
// Write mode serializes {hdr0,hdr1} MSB-first, then shifts out the CRC.
// Read mode captures 32 header bits plus 16 CRC bits, then checks the
// CRC remainder and compares the captured header with the expected one.
module rp_hdr_seq #(
  parameter int unsigned HDRBITS = 32,
  parameter int unsigned CRCBITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clken,
  input  logic               start,
  input  logic               mode,
  input  logic               abort,
  input  logic [15:0]        hdr0,
  input  logic [15:0]        hdr1,
  input  logic               rd_bit,
  input  logic [CRCBITS-1:0] hcrc_crc,
  output logic [1:0]         hcrc_op,
  output logic               hcrc_in,
  output logic               wr_bit,
  output logic               busy,
  output logic               done,
  output logic               crc_err,
  output logic               hdr_err,
  output logic [15:0]        rd_hdr0,
  output logic [15:0]        rd_hdr1
);

  localparam int unsigned CNTW  = 6;
  localparam int unsigned WORDW = 16;

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IN   = 2'b01;
  localparam logic [1:0] OP_OUT  = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_HDR  = 3'd2,
    S_CRC  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [HDRBITS-1:0] sreg_q, sreg_d;
  logic [HDRBITS-1:0] exp_q, exp_d;
  logic [HDRBITS-1:0] rd_hdr_q, rd_hdr_d;
  logic               mode_q, mode_d;
  logic               crc_err_q, crc_err_d;
  logic               hdr_err_q, hdr_err_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      exp_q     <= '0;
      rd_hdr_q  <= '0;
      mode_q    <= 1'b0;
      crc_err_q <= 1'b0;
      hdr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      exp_q     <= exp_d;
      rd_hdr_q  <= rd_hdr_d;
      mode_q    <= mode_d;
      crc_err_q <= crc_err_d;
      hdr_err_q <= hdr_err_d;
    end
  end

  // Next state and datapath updates; abort drops to IDLE holding everything else.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    exp_d     = exp_q;
    rd_hdr_d  = rd_hdr_q;
    mode_d    = mode_q;
    crc_err_d = crc_err_q;
    hdr_err_d = hdr_err_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_CLR;
            mode_d    = mode;
            sreg_d    = HDRBITS'({hdr0, hdr1});
            exp_d     = HDRBITS'({hdr0, hdr1});
            cnt_d     = '0;
            crc_err_d = 1'b0;
            hdr_err_d = 1'b0;
          end
        end
        S_CLR: begin
          if (clken) begin
            state_d = S_HDR;
            cnt_d   = '0;
          end
        end
        S_HDR: begin
          if (clken) begin
            sreg_d = {sreg_q[HDRBITS-2:0], (mode_q ? 1'b0 : rd_bit)};
            if (cnt_q == CNTW'(HDRBITS - 1)) begin
              state_d = S_CRC;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
        end
        S_CRC: begin
          if (clken) begin
            if (cnt_q == CNTW'(CRCBITS - 1)) begin
              state_d = S_FIN;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          if (!mode_q) begin
            crc_err_d = (hcrc_crc != '0);
            rd_hdr_d  = sreg_q;
            hdr_err_d = (sreg_q != exp_q);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // CRC block controls and serial outputs decoded from state, shifter and mode.
  always_comb begin
    hcrc_op = OP_IDLE;
    hcrc_in = 1'b0;
    wr_bit  = 1'b0;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    case (state_q)
      S_CLR: hcrc_op = OP_RST;
      S_HDR: begin
        hcrc_op = OP_IN;
        hcrc_in = mode_q ? sreg_q[HDRBITS-1] : rd_bit;
        wr_bit  = mode_q & sreg_q[HDRBITS-1];
      end
      S_CRC: begin
        hcrc_op = mode_q ? OP_OUT : OP_IN;
        hcrc_in = mode_q ? 1'b0 : rd_bit;
        wr_bit  = mode_q & hcrc_crc[CRCBITS-1];
      end
      S_FIN: done = !abort;
      default: ;
    endcase
  end

  assign crc_err = crc_err_q;
  assign hdr_err = hdr_err_q;
  assign rd_hdr0 = rd_hdr_q[HDRBITS-1 -: WORDW];
  assign rd_hdr1 = rd_hdr_q[WORDW-1:0];

endmodule
